// File: rtl/rc5_key_expand.sv
// RC5-32 key expansion (b=16, c=4): builds the packed subkey table S[0..2*ROUNDS+1] from a 128-bit key.
// Optional RC5_KEY_CACHE_EN: skip re-expansion when DONE sees the key it last expanded.
module rc5_key_expand #(
   parameter int unsigned ROUNDS = 12
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [127:0]               key_in,
   input  logic                       key_vld,
   output logic [32*(2*ROUNDS+2)-1:0] skey_out,
   output logic                       skey_rdy,
   output logic                       busy
);
   localparam int unsigned T    = 2*ROUNDS + 2;
   localparam int unsigned NMIX = 3 * ((T > 4) ? T : 4);
   localparam int unsigned IW   = $clog2(T);
   localparam int unsigned CW   = $clog2(NMIX);
   localparam logic [31:0] P32  = 32'hB7E15163;
   localparam logic [31:0] Q32  = 32'h9E3779B9;

   typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [31:0]     s_q [T];
   logic [31:0]     s_d [T];
   logic [31:0]     l_q [4];
   logic [31:0]     l_d [4];
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [IW-1:0]   i_q, i_d;
   logic [1:0]      j_q, j_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rdy_q, rdy_d, busy_q, busy_d;
   logic [31:0]     a_mix, b_mix, ab_sum;
   logic [IW-1:0]   init_idx, prev_idx;
   logic            cache_hit;

   // Rotate left; the doubled word makes a rotate by 0 an identity.
   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
      logic [63:0] w;
      w = {x, x} << r;
      return w[63:32];
   endfunction

`ifdef RC5_KEY_CACHE_EN
   logic [127:0] cache_key_q, cache_key_d;
   logic         cache_vld_q, cache_vld_d;

   always_comb begin
      cache_key_d = cache_key_q;
      cache_vld_d = cache_vld_q;
      if (state_d == INIT && state_q != INIT) begin
         cache_key_d = key_in;
         cache_vld_d = 1'b0;
      end else if (state_d == DONE && state_q == MIX) begin
         cache_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cache_key_q <= '0;
         cache_vld_q <= 1'b0;
      end else begin
         cache_key_q <= cache_key_d;
         cache_vld_q <= cache_vld_d;
      end
   end

   assign cache_hit = cache_vld_q && (key_in == cache_key_q);
`else
   assign cache_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      l_d     = l_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;

      init_idx = IW'(cnt_q);
      prev_idx = init_idx - IW'(1);
      a_mix    = rotl(s_q[i_q] + a_q + b_q, 5'd3);
      ab_sum   = a_mix + b_q;
      b_mix    = rotl(l_q[j_q] + ab_sum, ab_sum[4:0]);

      case (state_q)
         IDLE, DONE: begin
            if (key_vld && !(state_q == DONE && cache_hit)) begin
               for (int k = 0; k < 4; k++) l_d[k] = key_in[32*k +: 32];
               cnt_d   = '0;
               rdy_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = INIT;
            end
         end
         INIT: begin
            s_d[init_idx] = (cnt_q == '0) ? P32 : s_q[prev_idx] + Q32;
            if (cnt_q == CW'(T-1)) begin
               a_d     = '0;
               b_d     = '0;
               i_d     = '0;
               j_d     = '0;
               cnt_d   = '0;
               state_d = MIX;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         MIX: begin
            s_d[i_q] = a_mix;
            l_d[j_q] = b_mix;
            a_d      = a_mix;
            b_d      = b_mix;
            i_d      = (i_q == IW'(T-1)) ? '0 : i_q + IW'(1);
            j_d      = j_q + 2'd1;
            if (cnt_q == CW'(NMIX-1)) begin
               rdy_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         for (int k = 0; k < T; k++) s_q[k] <= '0;
         for (int k = 0; k < 4; k++) l_q[k] <= '0;
         a_q    <= '0;
         b_q    <= '0;
         i_q    <= '0;
         j_q    <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         l_q     <= l_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar g = 0; g < T; g++) begin : g_out
      assign skey_out[32*g +: 32] = s_q[g];
   end

   assign skey_rdy = rdy_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: ROUNDS=12 and ROUNDS=1 instances against a software RC5 key schedule.
module tb_rc5_key_expand;
   localparam int unsigned T0 = 26;
   localparam int unsigned T1 = 4;
   localparam logic [127:0] KEY_B = 128'h0123456789ABCDEF0FEDCBA987654321;

   typedef logic [31:0] tab_t [T0];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              clr, key_vld, clr1, key_vld1;
   logic [127:0]      key_in, key_in1;
   logic [32*T0-1:0]  skey0;
   logic [32*T1-1:0]  skey1;
   logic              rdy0, busy0, rdy1, busy1;

   int checks   = 0;
   int failures = 0;

   rc5_key_expand #(.ROUNDS(12)) dut0 (
      .clk(clk), .clr(clr), .key_in(key_in), .key_vld(key_vld),
      .skey_out(skey0), .skey_rdy(rdy0), .busy(busy0));

   rc5_key_expand #(.ROUNDS(1)) dut1 (
      .clk(clk), .clr(clr1), .key_in(key_in1), .key_vld(key_vld1),
      .skey_out(skey1), .skey_rdy(rdy1), .busy(busy1));

   function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
      if (r == 0) return x;
      return (x << r) | (x >> (32 - r));
   endfunction

   // Textbook RC5 key schedule with c=4 key words and t subkey words.
   task automatic model(input logic [127:0] key, input int t, output tab_t s);
      logic [31:0] l [4];
      logic [31:0] a, b;
      int i, j, n;
      for (int k = 0; k < T0; k++) s[k] = '0;
      for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
      s[0] = 32'hB7E15163;
      for (int k = 1; k < t; k++) s[k] = s[k-1] + 32'h9E3779B9;
      a = 0; b = 0; i = 0; j = 0;
      n = 3 * ((t > 4) ? t : 4);
      for (int m = 0; m < n; m++) begin
         a = rotl(s[i] + a + b, 3);
         s[i] = a;
         b = rotl(l[j] + a + b, int'((a + b) % 32));
         l[j] = b;
         i = (i + 1) % t;
         j = (j + 1) % 4;
      end
   endtask

   function automatic int first_diff0(input tab_t e);
      for (int k = 0; k < T0; k++) if (skey0[32*k +: 32] !== e[k]) return k;
      return -1;
   endfunction

   function automatic int first_diff1(input tab_t e);
      for (int k = 0; k < T1; k++) if (skey1[32*k +: 32] !== e[k]) return k;
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start0(input logic [127:0] k);
      key_in = k; key_vld = 1'b1;
      tick();
      key_vld = 1'b0;
   endtask

   task automatic wait_rdy0(input int base, output int cyc);
      cyc = base;
      while (rdy0 !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset;
      clr = 1'b1; clr1 = 1'b1;
      tick();
      clr = 1'b0; clr1 = 1'b0;
      checks++;
      if (rdy0 !== 1'b0 || busy0 !== 1'b0 || skey0 !== '0) begin
         failures++;
         $display("FAIL reset_r12: rdy=%b busy=%b skey_nonzero=%b, required 0 0 0", rdy0, busy0, |skey0);
      end
      checks++;
      if (rdy1 !== 1'b0 || busy1 !== 1'b0 || skey1 !== '0) begin
         failures++;
         $display("FAIL reset_r1: rdy=%b busy=%b skey=%h, required 0 0 0", rdy1, busy1, skey1);
      end
   endtask

   task automatic test_zero_key;
      tab_t exp;
      int cyc, d;
      logic [31:0] w;
      start0('0);
      checks++;
      if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin
         failures++;
         $display("FAIL accept: busy=%b rdy=%b, required 1 0", busy0, rdy0);
      end
      for (int k = 0; k < int'(T0); k++) tick();
      // End of INIT: arithmetic progression from P by Q.
      d = -1;
      w = 32'hB7E15163;
      for (int k = 0; k < int'(T0); k++) begin
         if (d < 0 && skey0[32*k +: 32] !== w) d = k;
         w = w + 32'h9E3779B9;
      end
      checks++;
      if (d >= 0) begin
         failures++;
         $display("FAIL init_table: S[%0d]=%h", d, skey0[32*d +: 32]);
      end
      checks++;
      if (skey0[31:0] !== 32'hB7E15163 || skey0[63:32] !== 32'h5618CB1C || skey0[95:64] !== 32'hF45044D5) begin
         failures++;
         $display("FAIL init_consts: S0..2=%h %h %h, required b7e15163 5618cb1c f45044d5",
                  skey0[31:0], skey0[63:32], skey0[95:64]);
      end
      wait_rdy0(int'(T0), cyc);
      checks++;
      if (cyc != 104) begin
         failures++;
         $display("FAIL zero_latency: got %0d, required 104", cyc);
      end
      model('0, T0, exp);
      d = first_diff0(exp);
      checks++;
      if (d >= 0) begin
         failures++;
         $display("FAIL zero_table: S[%0d]=%h, required %h", d, skey0[32*d +: 32], exp[d]);
      end
      checks++;
      if (skey0[31:0] !== 32'h9BBBD8C8 || skey0[63:32] !== 32'h1A37F7FB ||
          skey0[95:64] !== 32'h46F8E8C5 || skey0[32*25 +: 32] !== 32'h65046380) begin
         failures++;
         $display("FAIL zero_consts: S0=%h S1=%h S2=%h S25=%h, required 9bbbd8c8 1a37f7fb 46f8e8c5 65046380",
                  skey0[31:0], skey0[63:32], skey0[95:64], skey0[32*25 +: 32]);
      end
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (rdy0 !== 1'b1 || busy0 !== 1'b0 || first_diff0(exp) >= 0) begin
         failures++;
         $display("FAIL done_hold: rdy=%b busy=%b, required 1 0 with table stable", rdy0, busy0);
      end
   endtask

   task automatic test_reset_mid_mix;
      tab_t exp;
      int cyc, d;
      clr = 1'b1; tick(); clr = 1'b0;
      start0('0);
      for (int k = 0; k < 39; k++) tick();
      clr = 1'b1; key_in = '1; key_vld = 1'b1;
      tick();
      clr = 1'b0; key_vld = 1'b0;
      checks++;
      if (rdy0 !== 1'b0 || busy0 !== 1'b0 || skey0 !== '0) begin
         failures++;
         $display("FAIL mid_mix_reset: rdy=%b busy=%b skey_nonzero=%b, required 0 0 0", rdy0, busy0, |skey0);
      end
      start0('0);
      wait_rdy0(0, cyc);
      model('0, T0, exp);
      d = first_diff0(exp);
      checks++;
      if (cyc != 104 || d >= 0) begin
         failures++;
         $display("FAIL after_reset_zero: latency=%0d diff_at=%0d, required 104 -1", cyc, d);
      end
   endtask

   task automatic test_ignored_vld;
      tab_t exp;
      int cyc, d;
      clr = 1'b1; tick(); clr = 1'b0;
      start0('0);
      for (int k = 0; k < 10; k++) tick();
      key_in = '1; key_vld = 1'b1; tick(); key_vld = 1'b0;
      for (int k = 0; k < 30; k++) tick();
      key_vld = 1'b1; tick(); key_vld = 1'b0;
      wait_rdy0(42, cyc);
      model('0, T0, exp);
      d = first_diff0(exp);
      checks++;
      if (cyc != 104 || d >= 0) begin
         failures++;
         $display("FAIL ignored_vld: latency=%0d diff_at=%0d, required 104 -1", cyc, d);
      end
   endtask

   task automatic test_restart;
      tab_t exp, zexp;
      int cyc, d, nd;
      model('0, T0, zexp);
      model(KEY_B, T0, exp);
      start0(KEY_B);
      checks++;
      if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL restart_edge: rdy=%b busy=%b, required 0 1", rdy0, busy0);
      end
      wait_rdy0(0, cyc);
      d  = first_diff0(exp);
      nd = first_diff0(zexp);
      checks++;
      if (cyc != 104 || d >= 0 || nd < 0) begin
         failures++;
         $display("FAIL restart_table: latency=%0d diff_at=%0d zero_diff_at=%0d, required 104 -1 >=0", cyc, d, nd);
      end
`ifdef RC5_KEY_CACHE_EN
      start0(KEY_B);
      tick();
      checks++;
      if (rdy0 !== 1'b1 || busy0 !== 1'b0 || first_diff0(exp) >= 0) begin
         failures++;
         $display("FAIL cache_hit: rdy=%b busy=%b, required 1 0 with table kept", rdy0, busy0);
      end
`else
      start0(KEY_B);
      wait_rdy0(0, cyc);
      d = first_diff0(exp);
      checks++;
      if (cyc != 104 || d >= 0) begin
         failures++;
         $display("FAIL repeat_key: latency=%0d diff_at=%0d, required 104 -1", cyc, d);
      end
`endif
   endtask

   task automatic test_back_to_back;
      tab_t exp;
      logic [127:0] k;
      int cyc, d;
      for (int n = 0; n < 4; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         model(k, T0, exp);
         start0(k);
         key_in = {$urandom, $urandom, $urandom, $urandom};
         wait_rdy0(0, cyc);
         d = first_diff0(exp);
         checks++;
         if (cyc != 104 || d >= 0) begin
            failures++;
            $display("FAIL random_key%0d: key=%h latency=%0d diff_at=%0d, required 104 -1", n, k, cyc, d);
         end
      end
   endtask

   task automatic test_rounds1;
      tab_t exp;
      logic [127:0] k;
      int cyc, d;
      clr1 = 1'b1; tick(); clr1 = 1'b0;
      for (int n = 0; n < 4; n++) begin
         k = (n == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
         model(k, T1, exp);
         key_in1 = k; key_vld1 = 1'b1; tick(); key_vld1 = 1'b0;
         cyc = 0;
         while (rdy1 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
         end
         d = first_diff1(exp);
         checks++;
         if (cyc != 16 || d >= 0) begin
            failures++;
            $display("FAIL rounds1_key%0d: latency=%0d diff_at=%0d skey=%h, required 16 -1", n, cyc, d, skey1);
         end
      end
   endtask

   initial begin
      clr = 1'b0; key_vld = 1'b0; key_in = '0;
      clr1 = 1'b0; key_vld1 = 1'b0; key_in1 = '0;
      #2;
      test_reset();
      test_zero_key();
      test_reset_mid_mix();
      test_ignored_vld();
      test_restart();
      test_back_to_back();
      test_rounds1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
